// File: rtl/hex_reg_arbiter.sv
// Shared 6-bit register bank arbitrated between N_REQ requesters (IDLE -> LOAD -> HOLD).
// Define HEX_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
//
// state  | meaning
// S_IDLE | no grant outstanding; arbitrate among raised requests
// S_LOAD | grant held one cycle; capture winner word if its request persists
// S_HOLD | Q held stable for HOLD_CYCLES cycles; requests ignored
module hex_reg_arbiter #(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 6,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                   clk_i,
   input  logic                   clr_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*WIDTH-1:0] data_i,
   output logic [N_REQ-1:0]       gnt_o,
   output logic [N_REQ-1:0]       ack_o,
   output logic [WIDTH-1:0]       q_o,
   output logic [2:0]             owner_o,
   output logic                   valid_o,
   output logic                   busy_o
);

   localparam int IW = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic             valid_q, valid_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IW-1:0]    win_q, win_d;
`ifndef HEX_ARB_FIXED_PRIO_EN
   logic [IW-1:0]    ptr_q, ptr_d;
   int               idx;
`endif

   logic [7:0]       req_pad;
   logic [IW-1:0]    pick;
   logic             found;
   logic [N_REQ-1:0] pick_oh;
   logic [WIDTH-1:0] data_sel;

   assign req_pad = 8'(req_i);

   always_comb begin
      pick  = '0;
      found = 1'b0;
`ifdef HEX_ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_pad[i]) begin
            pick  = IW'(i);
            found = 1'b1;
         end
      end
`else
      idx = 0;
      // Scan starting at the pointer so the last winner goes to the back of the line.
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr_q) + k) % N_REQ;
         if (!found && req_pad[idx[IW-1:0]]) begin
            pick  = idx[IW-1:0];
            found = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      pick_oh  = '0;
      data_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         pick_oh[i] = (pick == IW'(i));
         if (win_q == IW'(i)) data_sel = data_i[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = '0;
      ack_d   = '0;
      q_d     = q_q;
      owner_d = owner_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
`ifndef HEX_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d   = pick;
               gnt_d   = pick_oh;
               state_d = S_LOAD;
`ifndef HEX_ARB_FIXED_PRIO_EN
               ptr_d   = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
`endif
            end
         end
         S_LOAD: begin
            if (req_pad[win_q]) begin
               q_d     = data_sel;
               owner_d = win_q;
               valid_d = 1'b1;
               ack_d   = gnt_q;
               cnt_d   = 4'(HOLD_CYCLES);
               state_d = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         ack_q   <= '0;
         q_q     <= '0;
         owner_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         win_q   <= '0;
`ifndef HEX_ARB_FIXED_PRIO_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         owner_q <= owner_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
`ifndef HEX_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign gnt_o   = gnt_q;
   assign ack_o   = ack_q;
   assign q_o     = q_q;
   assign owner_o = owner_q;
   assign valid_o = valid_q;
   assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_hex_reg_arbiter.sv
// Directed bench for hex_reg_arbiter: cycle table for HOLD_CYCLES=2 plus a HOLD_CYCLES=0 instance.
module tb_hex_reg_arbiter;

`ifdef HEX_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct {
      logic        clr;
      logic [3:0]  req;
      logic [23:0] data;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [5:0]  q;
      logic [2:0]  owner;
      logic        valid;
      logic        busy;
   } vec_t;

   logic        clk, clr;
   logic [3:0]  req_a, req_b;
   logic [23:0] data_a, data_b;
   logic [3:0]  gnt_a, ack_a, gnt_b, ack_b;
   logic [5:0]  q_a, q_b;
   logic [2:0]  owner_a, owner_b;
   logic        valid_a, busy_a, valid_b, busy_b;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[$];

   hex_reg_arbiter #(.N_REQ(4), .WIDTH(6), .HOLD_CYCLES(2)) dut_a (
      .clk_i(clk), .clr_i(clr), .req_i(req_a), .data_i(data_a),
      .gnt_o(gnt_a), .ack_o(ack_a), .q_o(q_a), .owner_o(owner_a),
      .valid_o(valid_a), .busy_o(busy_a)
   );

   hex_reg_arbiter #(.N_REQ(4), .WIDTH(6), .HOLD_CYCLES(0)) dut_b (
      .clk_i(clk), .clr_i(clr), .req_i(req_b), .data_i(data_b),
      .gnt_o(gnt_b), .ack_o(ack_b), .q_o(q_b), .owner_o(owner_b),
      .valid_o(valid_b), .busy_o(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] g, input logic [3:0] a,
                        input logic [5:0] q, input logic [2:0] o, input logic v, input logic b);
      chk({tag, ".gnt"},   32'(gnt_a),   32'(g));
      chk({tag, ".ack"},   32'(ack_a),   32'(a));
      chk({tag, ".q"},     32'(q_a),     32'(q));
      chk({tag, ".owner"}, 32'(owner_a), 32'(o));
      chk({tag, ".valid"}, 32'(valid_a), 32'(v));
      chk({tag, ".busy"},  32'(busy_a),  32'(b));
   endtask

   function automatic vec_t mk(input logic c, input logic [3:0] r, input logic [23:0] d,
                               input logic [3:0] g, input logic [3:0] a, input logic [5:0] q,
                               input logic [2:0] o, input logic v, input logic b);
      vec_t t;
      t.clr = c; t.req = r; t.data = d; t.gnt = g; t.ack = a;
      t.q = q; t.owner = o; t.valid = v; t.busy = b;
      return t;
   endfunction

   localparam logic [23:0] D_A = {6'h04, 6'h03, 6'h2A, 6'h01};
   localparam logic [23:0] D_B = {6'h04, 6'h03, 6'h02, 6'h01};
   localparam logic [23:0] D_C = {6'h3F, 6'h03, 6'h02, 6'h3F};

   initial begin
      logic [5:0] pq;
      logic [2:0] po;
      logic       pv;
      int         w;
      string      tag;

      // Idle after reset, then a single load from requester 1.
      for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 4'b0000, D_A, 0, 0, 6'h00, 0, 0, 0));
      vecs.push_back(mk(0, 4'b0010, D_A, 4'b0010, 0,       6'h00, 0, 0, 1));
      vecs.push_back(mk(0, 4'b0010, D_A, 4'b0000, 4'b0010, 6'h2A, 1, 1, 1));
      vecs.push_back(mk(0, 4'b0000, D_A, 4'b0000, 0,       6'h2A, 1, 1, 1));
      vecs.push_back(mk(0, 4'b0000, D_A, 4'b0000, 0,       6'h2A, 1, 1, 0));
      vecs.push_back(mk(0, 4'b0000, D_A, 4'b0000, 0,       6'h2A, 1, 1, 0));
      vecs.push_back(mk(1, 4'b0000, D_A, 4'b0000, 0,       6'h00, 0, 0, 0));
      // All four requesting continuously: five grants, 4 cycles each.
      pq = 6'h00; po = 3'd0; pv = 1'b0;
      for (int g = 0; g < 5; g++) begin
         w = FIXED ? 0 : g % 4;
         vecs.push_back(mk(0, 4'b1111, D_B, 4'b0001 << w, 0, pq, po, pv, 1));
         pq = 6'(w + 1); po = 3'(w); pv = 1'b1;
         vecs.push_back(mk(0, 4'b1111, D_B, 0, 4'b0001 << w, pq, po, pv, 1));
         vecs.push_back(mk(0, 4'b1111, D_B, 0, 0, pq, po, pv, 1));
         vecs.push_back(mk(0, 4'b1111, D_B, 0, 0, pq, po, pv, 0));
      end

      clr = 1'b1; req_a = '0; req_b = '0; data_a = '0; data_b = '0;
      step(); step();
      clr = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         clr = vecs[i].clr; req_a = vecs[i].req; data_a = vecs[i].data;
         step();
         tag = $sformatf("vec%0d", i);
         chk_a(tag, vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].owner, vecs[i].valid, vecs[i].busy);
      end

      // Requester 2 drops its request during LOAD: abort, Q kept, pointer still advanced.
      req_a = 4'b0100;
      step();
      chk_a("abort_gnt", 4'b0100, 0, 6'h01, 0, 1, 1);
      req_a = 4'b0000;
      step();
      chk_a("abort_drop", 4'b0000, 0, 6'h01, 0, 1, 0);
      w = FIXED ? 0 : 3;
      req_a = 4'b1001; data_a = D_C;
      step();
      chk_a("post_abort_gnt", 4'b0001 << w, 0, 6'h01, 0, 1, 1);
      step();
      chk_a("load_3f", 0, 4'b0001 << w, 6'h3F, 3'(w), 1, 1);
      data_a = 24'h0;
      step();
      chk_a("hold_stable", 0, 0, 6'h3F, 3'(w), 1, 1);

      // Asynchronous clear mid-HOLD.
      #2 clr = 1'b1;
      #1;
      chk_a("async_clr", 0, 0, 6'h00, 0, 0, 0);
      clr = 1'b0; req_a = 4'b1111; data_a = D_B;
      step();
      chk_a("restart_gnt", 4'b0001, 0, 6'h00, 0, 0, 1);
      step();
      chk_a("restart_load", 0, 4'b0001, 6'h01, 0, 1, 1);
      req_a = 4'b0000;

      // HOLD_CYCLES=0 instance: loads every second cycle alternating 0 and 2.
      req_b = 4'b0101; data_b = D_B;
      for (int k = 0; k < 4; k++) begin
         w = FIXED ? 0 : (k % 2) * 2;
         step();
         chk($sformatf("b%0d.gnt", k), 32'(gnt_b), 32'(4'b0001 << w));
         chk($sformatf("b%0d.busy", k), 32'(busy_b), 32'd1);
         step();
         chk($sformatf("b%0d.q", k), 32'(q_b), 32'(w + 1));
         chk($sformatf("b%0d.ack", k), 32'(ack_b), 32'(4'b0001 << w));
         chk($sformatf("b%0d.owner", k), 32'(owner_b), 32'(w));
         chk($sformatf("b%0d.busy_lo", k), 32'(busy_b), 32'd0);
      end
      req_b = 4'b0000;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
